rf_write_sched: RTL

Write-port scheduler for the 32×32 register file. It merges three write sources onto the file's single write port (WriteReg/ND/DI):

- the writeback stage,
- queued JAL link writes to r31,
- results from the long-latency (mul/div) unit.

It also keeps a per-register busy scoreboard so decode can stall on outstanding long-latency destinations. It sits between the pipeline's WB/EX logic and the register file.

---
 rtl/rf_write_sched.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_write_sched.sv
// rtl/rf_write_sched.sv - write-port scheduler and busy scoreboard for the 32x32 register file
//
// Merges three write sources onto the single register-file write port:
// writeback (highest priority, never stalled), an aged long-latency (LU)
// result, the JAL link queue head (always r31), and a fresh LU result.
// Also tracks per-register busy bits for outstanding long-latency ops so
// decode can stall on them.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   wb_we/wb_nd/wb_di     writeback write request
//   jal_valid/jal_data    push a link value destined for r31
//   jal_full, lq_ovf      link queue full, sticky overflow (dropped push)
//   lu_valid/lu_nd/lu_di  long-latency result, held until lu_ready
//   lu_ready              LU result accepted this cycle (combinational)
//   iss_valid/iss_nd      long-latency op issued to destination iss_nd
//   rs, rt, stall         decode sources and resulting stall (combinational)
//   busy                  scoreboard
//   WriteReg/ND/DI        registered register-file write port

module rf_write_sched #(
    parameter int LQ_DEPTH = 2,
    parameter int AGE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_nd,
    input  logic [31:0] wb_di,
    input  logic        jal_valid,
    input  logic [31:0] jal_data,
    output logic        jal_full,
    output logic        lq_ovf,
    input  logic        lu_valid,
    input  logic [4:0]  lu_nd,
    input  logic [31:0] lu_di,
    output logic        lu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_nd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        stall,
    output logic [31:0] busy,
    output logic        WriteReg,
    output logic [4:0]  ND,
    output logic [31:0] DI
);

    localparam int LQ_PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int LQ_CW = LQ_PW + 1;
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    localparam logic [LQ_CW-1:0] LQ_FULL_CNT = LQ_CW'(LQ_DEPTH);
    localparam logic [AGE_W-1:0] AGE_LIMIT   = AGE_W'(AGE_MAX);
    localparam logic [4:0]       LINK_REG    = 5'd31;

    // link queue state
    logic [31:0]      lq_mem_q [LQ_DEPTH];
    logic [31:0]      lq_mem_d [LQ_DEPTH];
    logic [LQ_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LQ_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LQ_CW-1:0] count_q, count_d;
    logic             lq_ovf_q, lq_ovf_d;

    // LU aging and scoreboard
    logic [AGE_W-1:0] age_q, age_d;
    logic [31:0]      busy_q, busy_d;

    // registered write port
    logic             write_reg_q, write_reg_d;
    logic [4:0]       nd_q, nd_d;
    logic [31:0]      di_q, di_d;

    // arbitration
    logic lq_empty;
    logic lq_full;
    logic lu_aged;
    logic grant_wb;
    logic grant_lu;
    logic grant_lq;
    logic do_push;

    assign lq_empty = (count_q == '0);
    assign lq_full  = (count_q == LQ_FULL_CNT);
    assign lu_aged  = lu_valid && (age_q >= AGE_LIMIT);

    assign grant_wb = wb_we;
    // A fresh LU result only beats the link queue once it has aged; before
    // that it wins only when the queue has nothing to offer.
    assign grant_lu = !wb_we && lu_valid && (lu_aged || lq_empty);
    assign grant_lq = !wb_we && !lu_aged && !lq_empty;

    // A pop in the same cycle frees a slot, so a push into a full queue is
    // accepted then; the new entry lands behind the head and is never the
    // one popped this cycle.
    assign do_push  = jal_valid && (!lq_full || grant_lq);

    always_comb begin
        lq_mem_d = lq_mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        lq_ovf_d = lq_ovf_q;

        if (do_push) begin
            lq_mem_d[wr_ptr_q] = jal_data;
            wr_ptr_d           = wr_ptr_q + LQ_PW'(1);
        end
        if (grant_lq) begin
            rd_ptr_d = rd_ptr_q + LQ_PW'(1);
        end
        if (do_push && !grant_lq) begin
            count_d = count_q + LQ_CW'(1);
        end else if (!do_push && grant_lq) begin
            count_d = count_q - LQ_CW'(1);
        end
        if (jal_valid && !do_push) begin
            lq_ovf_d = 1'b1;
        end
    end

    always_comb begin
        age_d = age_q;
        if (!lu_valid || grant_lu) begin
            age_d = '0;
        end else if (age_q < AGE_LIMIT) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    // Clear first, then set, so an issue to the same register that the LU
    // retires this cycle leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (grant_lu) begin
            busy_d[lu_nd] = 1'b0;
        end
        if (iss_valid && (iss_nd != 5'd0)) begin
            busy_d[iss_nd] = 1'b1;
        end
    end

    // Grants to r0 still update ND/DI but never raise WriteReg.
    always_comb begin
        write_reg_d = 1'b0;
        nd_d        = nd_q;
        di_d        = di_q;
        if (grant_wb) begin
            nd_d        = wb_nd;
            di_d        = wb_di;
            write_reg_d = (wb_nd != 5'd0);
        end else if (grant_lu) begin
            nd_d        = lu_nd;
            di_d        = lu_di;
            write_reg_d = (lu_nd != 5'd0);
        end else if (grant_lq) begin
            nd_d        = LINK_REG;
            di_d        = lq_mem_q[rd_ptr_q];
            write_reg_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            lq_ovf_q    <= 1'b0;
            age_q       <= '0;
            busy_q      <= '0;
            write_reg_q <= 1'b0;
            nd_q        <= '0;
            di_q        <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            lq_ovf_q    <= lq_ovf_d;
            age_q       <= age_d;
            busy_q      <= busy_d;
            write_reg_q <= write_reg_d;
            nd_q        <= nd_d;
            di_q        <= di_d;
        end
    end

    // Queue payload needs no reset: the count alone decides validity.
    always_ff @(posedge clk) begin
        lq_mem_q <= lq_mem_d;
    end

    // Handshake and stall are forced low while reset is held so no source
    // believes it was accepted during reset.
    assign lu_ready = reset && grant_lu;
    assign stall    = reset && (busy_q[rs] || busy_q[rt] ||
                      (!lq_empty && ((rs == LINK_REG) || (rt == LINK_REG))));

    assign jal_full = lq_full;
    assign lq_ovf   = lq_ovf_q;
    assign busy     = busy_q;
    assign WriteReg = write_reg_q;
    assign ND       = nd_q;
    assign DI       = di_q;

endmodule
